pwm_pair_monitor: RTL and testbench

//  Downstream observer of one Segway motor bridge output pair (PWM1_x/PWM2_x).
//  - Measures PWM1 period and high-time every cycle of the waveform.
//  - Flags shoot-through (both high) and insufficient dead time between the pair.
//  - Flags a stuck (non-toggling) PWM1. Feeds the system bench scoreboard; one instance per motor.

---
 rtl/pwm_pair_monitor.sv | 180 ++++++++++++++++++
 tb/tb_pwm_pair_monitor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_pair_monitor.sv
// pwm_pair_monitor: watches one motor-bridge output pair (pwm1/pwm2).
// It measures the pwm1 period and high time once per waveform period, and raises
// sticky flags for shoot-through and short dead time. It also flags a pwm1 that has
// stopped toggling.
module pwm_pair_monitor #(
   parameter int CNT_W    = 12,
   parameter int DEAD_MIN = 16,
   parameter int TIMEOUT  = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm1,
   input  logic             pwm2,
   input  logic             clr_err,
   output logic [CNT_W-1:0] duty,
   output logic [CNT_W-1:0] period,
   output logic             meas_vld,
   output logic             shoot_err,
   output logic             dead_err,
   output logic             stuck,
   output logic             stuck_lvl
);

   // The period counter must be able to reach TIMEOUT even when TIMEOUT == 2^CNT_W.
   // The reported values are clipped back to CNT_W bits.
   localparam int               TO_W       = $clog2(TIMEOUT + 1);
   localparam int               PER_W      = (TO_W > CNT_W) ? TO_W : CNT_W;
   localparam logic [PER_W-1:0] TIMEOUT_C  = PER_W'(TIMEOUT);
   localparam logic [PER_W-1:0] ONE_C      = PER_W'(1);
   localparam logic [PER_W-1:0] OUT_MAX    = PER_W'({CNT_W{1'b1}});
   localparam logic [CNT_W-1:0] DEAD_MIN_C = CNT_W'(DEAD_MIN);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   // Saturating increment of the internal period/high-time counters.
   function automatic logic [PER_W-1:0] sat_inc_per(input logic [PER_W-1:0] v);
      return (&v) ? v : v + ONE_C;
   endfunction

   // Saturating increment of the dead-time gap counter.
   function automatic logic [CNT_W-1:0] sat_inc_gap(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Clip an internal count to the CNT_W-bit output range.
   function automatic logic [CNT_W-1:0] clip_out(input logic [PER_W-1:0] v);
      if (v > OUT_MAX) begin
         return {CNT_W{1'b1}};
      end
      return v[CNT_W-1:0];
   endfunction

   logic             p1_q, p2_q;
   logic             rise1, rise2;
   state_t           state_q, state_d;
   logic [PER_W-1:0] per_cnt_q, per_cnt_d;
   logic [PER_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             meas_vld_q, meas_vld_d;
   logic             stuck_q, stuck_d;
   logic             stuck_lvl_q, stuck_lvl_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic             shoot_q, shoot_d;
   logic             dead_q, dead_d;

   assign rise1 = pwm1 & ~p1_q;
   assign rise2 = pwm2 & ~p2_q;

   // Edge-detect history. It follows the inputs even through reset, so only a genuine
   // low-to-high transition is ever taken as a rise.
   always_ff @(posedge clk) begin
      p1_q <= pwm1;
      p2_q <= pwm2;
   end

   // Measurement FSM: next state, counters, latched results and stuck detection.
   always_comb begin
      state_d     = state_q;
      per_cnt_d   = per_cnt_q;
      hi_cnt_d    = hi_cnt_q;
      duty_d      = duty_q;
      period_d    = period_q;
      meas_vld_d  = 1'b0;
      stuck_d     = stuck_q;
      stuck_lvl_d = stuck_lvl_q;
      case (state_q)
         S_IDLE: begin
            // The first rise only sets the reference edge. Nothing is measured yet.
            if (rise1) begin
               state_d   = S_RUN;
               per_cnt_d = ONE_C;
               hi_cnt_d  = ONE_C;
               stuck_d   = 1'b0;
            end
         end
         S_RUN: begin
            if (rise1) begin
               // Close the current period. The rise cycle opens the next period.
               period_d   = clip_out(per_cnt_q);
               duty_d     = clip_out(hi_cnt_q);
               meas_vld_d = 1'b1;
               per_cnt_d  = ONE_C;
               hi_cnt_d   = ONE_C;
            end else if (per_cnt_q >= TIMEOUT_C) begin
               // No rise for TIMEOUT cycles means the output is stuck at 0% or 100% duty.
               stuck_d     = 1'b1;
               stuck_lvl_d = pwm1;
               state_d     = S_IDLE;
            end else begin
               per_cnt_d = sat_inc_per(per_cnt_q);
               if (pwm1) begin
                  hi_cnt_d = sat_inc_per(hi_cnt_q);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Pair checks. A new error takes priority over a simultaneous clear.
   always_comb begin
      gap_d   = pwm1 | pwm2 ? '0 : sat_inc_gap(gap_q);
      shoot_d = shoot_q;
      dead_d  = dead_q;
      if (pwm1 & pwm2) begin
         shoot_d = 1'b1;
      end else if (clr_err) begin
         shoot_d = 1'b0;
      end
      if ((rise1 | rise2) && (gap_q < DEAD_MIN_C)) begin
         dead_d = 1'b1;
      end else if (clr_err) begin
         dead_d = 1'b0;
      end
   end

   // State register. Reset discards any partial measurement and clears every output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         per_cnt_q   <= '0;
         hi_cnt_q    <= '0;
         duty_q      <= '0;
         period_q    <= '0;
         meas_vld_q  <= 1'b0;
         stuck_q     <= 1'b0;
         stuck_lvl_q <= 1'b0;
         gap_q       <= DEAD_MIN_C;
         shoot_q     <= 1'b0;
         dead_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         per_cnt_q   <= per_cnt_d;
         hi_cnt_q    <= hi_cnt_d;
         duty_q      <= duty_d;
         period_q    <= period_d;
         meas_vld_q  <= meas_vld_d;
         stuck_q     <= stuck_d;
         stuck_lvl_q <= stuck_lvl_d;
         gap_q       <= gap_d;
         shoot_q     <= shoot_d;
         dead_q      <= dead_d;
      end
   end

   assign duty      = duty_q;
   assign period    = period_q;
   assign meas_vld  = meas_vld_q;
   assign shoot_err = shoot_q;
   assign dead_err  = dead_q;
   assign stuck     = stuck_q;
   assign stuck_lvl = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_pair_monitor.sv
// Testbench for pwm_pair_monitor. It uses an event/timestamp model of the pair rules
// and directed waveforms with literal expectations.
module tb_pwm_pair_monitor;

   localparam int CNT_W    = 12;
   localparam int DEAD_MIN = 16;
   localparam int TIMEOUT  = 4096;
   localparam int OUT_MAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             pwm1 = 1'b0;
   logic             pwm2 = 1'b0;
   logic             clr_err = 1'b0;
   logic [CNT_W-1:0] duty, period;
   logic             meas_vld, shoot_err, dead_err, stuck, stuck_lvl;

   always #5 clk = ~clk;

   pwm_pair_monitor #(.CNT_W(CNT_W), .DEAD_MIN(DEAD_MIN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .pwm1(pwm1), .pwm2(pwm2), .clr_err(clr_err),
      .duty(duty), .period(period), .meas_vld(meas_vld), .shoot_err(shoot_err),
      .dead_err(dead_err), .stuck(stuck), .stuck_lvl(stuck_lvl)
   );

   int n_chk = 0;
   int n_fail = 0;
   int n_print = 0;
   int vld_cnt = 0;
   int last_duty = 0;
   int last_period = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         if (n_print < 40) begin
            n_print++;
            $display("FAIL %s: actual %0d required %0d at time %0t", name, act, exp, $time);
         end
      end
   endtask

   // Model state: timestamps of the last rise and last active cycle, plus pwm1 samples since the last rise.
   bit m_prev1 = 0, m_prev2 = 0, m_armed = 0, m_have_act = 0;
   int m_cyc = 0, m_last_rise = 0, m_last_act = 0;
   bit m_hist[$];
   int m_duty = 0, m_period = 0;
   bit m_vld = 0, m_shoot = 0, m_dead = 0, m_stuck = 0, m_lvl = 0;

   // Compare process: advance the model by the edge just passed, then check every output.
   initial begin : compare
      bit r1, r2;
      int ones, gap;
      @(posedge clk);
      forever begin
         @(negedge clk);
         m_cyc++;
         r1 = pwm1 && !m_prev1;
         r2 = pwm2 && !m_prev2;
         m_vld = 0;
         if (rst) begin
            m_duty = 0; m_period = 0; m_shoot = 0; m_dead = 0; m_stuck = 0; m_lvl = 0;
            m_armed = 0; m_have_act = 0; m_hist.delete();
         end else begin
            gap = m_have_act ? (m_cyc - m_last_act - 1) : DEAD_MIN;
            if ((r1 || r2) && gap < DEAD_MIN) m_dead = 1;
            else if (clr_err) m_dead = 0;
            if (pwm1 && pwm2) m_shoot = 1;
            else if (clr_err) m_shoot = 0;
            if (pwm1 || pwm2) begin
               m_have_act = 1;
               m_last_act = m_cyc;
            end
            if (m_armed) begin
               if (r1) begin
                  ones = 0;
                  foreach (m_hist[i]) ones += int'(m_hist[i]);
                  m_period = (m_cyc - m_last_rise > OUT_MAX) ? OUT_MAX : m_cyc - m_last_rise;
                  m_duty = (ones > OUT_MAX) ? OUT_MAX : ones;
                  m_vld = 1;
                  m_last_rise = m_cyc;
                  m_hist.delete();
                  m_hist.push_back(pwm1);
               end else if (m_cyc - m_last_rise == TIMEOUT) begin
                  m_stuck = 1;
                  m_lvl = pwm1;
                  m_armed = 0;
               end else begin
                  m_hist.push_back(pwm1);
               end
            end else if (r1) begin
               m_armed = 1;
               m_stuck = 0;
               m_last_rise = m_cyc;
               m_hist.delete();
               m_hist.push_back(pwm1);
            end
         end
         m_prev1 = pwm1;
         m_prev2 = pwm2;
         chk("model_duty", int'(duty), m_duty);
         chk("model_period", int'(period), m_period);
         chk("model_meas_vld", int'(meas_vld), int'(m_vld));
         chk("model_shoot_err", int'(shoot_err), int'(m_shoot));
         chk("model_dead_err", int'(dead_err), int'(m_dead));
         chk("model_stuck", int'(stuck), int'(m_stuck));
         chk("model_stuck_lvl", int'(stuck_lvl), int'(m_lvl));
         if (meas_vld) begin
            vld_cnt++;
            last_duty = int'(duty);
            last_period = int'(period);
         end
      end
   end

   // One clock of stimulus. The vector is sampled at the next rising edge, and the call returns just after the
   // following falling edge, when that edge's results are visible.
   task automatic cyc(input bit a, input bit b, input bit c);
      pwm1 = a;
      pwm2 = b;
      clr_err = c;
      @(negedge clk);
      #2;
   endtask

   task automatic seg(input bit a, input bit b, input int n);
      for (int i = 0; i < n; i++) cyc(a, b, 1'b0);
   endtask

   // Standard bridge waveform: pwm1 high, 32 idle, pwm2 high, 32 idle.
   task automatic pwm_cycles(input int hi, input int per, input int start, input int n);
      for (int i = start; i < start + n; i++) begin
         if (i < hi) cyc(1'b1, 1'b0, 1'b0);
         else if (i < hi + 32) cyc(1'b0, 1'b0, 1'b0);
         else if (i < per - 32) cyc(1'b0, 1'b1, 1'b0);
         else cyc(1'b0, 1'b0, 1'b0);
      end
   endtask

   function automatic int all_outs();
      return int'({duty, period, meas_vld, shoot_err, dead_err, stuck, stuck_lvl});
   endfunction

   initial begin : stim
      int v0;
      rst = 1'b1;
      @(negedge clk);
      #2;
      seg(1'b0, 1'b0, 3);
      chk("reset_outputs_zero", all_outs(), 0);
      rst = 1'b0;

      // Steady 512/2048 waveform.
      for (int p = 0; p < 4; p++) pwm_cycles(512, 2048, 0, 2048);
      chk("steady_vld_count", vld_cnt, 3);
      chk("steady_duty", last_duty, 512);
      chk("steady_period", last_period, 2048);
      chk("steady_no_errors", int'({shoot_err, dead_err, stuck}), 0);

      // Duty change from 512 to 1500. The first report after the change is still the old duty.
      pwm_cycles(1500, 2048, 0, 2048);
      chk("dutychg_first_report", last_duty, 512);
      pwm_cycles(1500, 2048, 0, 2048);
      chk("dutychg_second_report", last_duty, 1500);
      chk("dutychg_period", last_period, 2048);
      chk("dutychg_vld_count", vld_cnt, 5);

      // Dead time.
      seg(1'b1, 1'b0, 20);
      seg(1'b0, 1'b0, 10);
      cyc(1'b0, 1'b1, 1'b0);
      chk("gap10_dead_err", int'(dead_err), 1);
      seg(1'b0, 1'b1, 19);
      seg(1'b0, 1'b0, 5);
      cyc(1'b0, 1'b0, 1'b1);
      chk("clr_dead_err", int'(dead_err), 0);
      seg(1'b0, 1'b0, 10);
      seg(1'b1, 1'b0, 20);
      chk("gap16_legal", int'(dead_err), 0);
      seg(1'b0, 1'b0, 10);
      cyc(1'b0, 1'b1, 1'b1);
      chk("clr_vs_new_err", int'(dead_err), 1);
      seg(1'b0, 1'b1, 10);
      seg(1'b0, 1'b0, 16);

      // Shoot-through.
      seg(1'b1, 1'b0, 5);
      chk("no_shoot_before", int'(shoot_err), 0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("overlap_shoot", int'(shoot_err), 1);
      chk("overlap_dead", int'(dead_err), 1);
      seg(1'b1, 1'b0, 3);
      chk("shoot_held", int'(shoot_err), 1);
      seg(1'b0, 1'b0, 16);
      cyc(1'b0, 1'b0, 1'b1);
      chk("clr_shoot", int'({shoot_err, dead_err}), 0);

      // Stuck low: declared exactly TIMEOUT cycles after the last rise.
      seg(1'b1, 1'b0, 100);
      seg(1'b0, 1'b0, TIMEOUT - 100);
      chk("stuck_low_not_early", int'(stuck), 0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("stuck_low_set", int'(stuck), 1);
      chk("stuck_low_lvl", int'(stuck_lvl), 0);
      v0 = vld_cnt;
      cyc(1'b1, 1'b0, 1'b0);
      chk("stuck_clear_on_rise", int'(stuck), 0);
      seg(1'b1, 1'b0, 49);
      seg(1'b0, 1'b0, 50);
      chk("no_vld_first_rise", vld_cnt, v0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("vld_second_rise", vld_cnt, v0 + 1);
      chk("resume_duty", last_duty, 50);
      chk("resume_period", last_period, 100);

      // Stuck high.
      seg(1'b1, 1'b0, TIMEOUT - 1);
      chk("stuck_high_not_early", int'(stuck), 0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("stuck_high_set", int'(stuck), 1);
      chk("stuck_high_lvl", int'(stuck_lvl), 1);
      seg(1'b0, 1'b0, 20);

      // Reset 700 cycles into a period.
      pwm_cycles(512, 2048, 0, 2048);
      pwm_cycles(512, 2048, 0, 700);
      rst = 1'b1;
      cyc(1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      chk("midreset_outputs_zero", all_outs(), 0);
      pwm_cycles(512, 2048, 701, 2048 - 701);
      v0 = vld_cnt;
      pwm_cycles(512, 2048, 0, 2048);
      chk("postreset_no_vld", vld_cnt, v0);
      pwm_cycles(512, 2048, 0, 2048);
      chk("postreset_vld", vld_cnt, v0 + 1);
      chk("postreset_duty", last_duty, 512);
      chk("postreset_period", last_period, 2048);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
